// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline register.
// Occupancy counter sizing lives here so the top and any wrapper agree on it.
package pipe_reg_pkg;

  // Bits needed to hold 0..2*stages words.
  function automatic int unsigned cnt_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// One elastic slice: main + skid register behind a 3-state occupancy FSM.
// in_ready and out_valid come straight from flops, so no out_ready->in_ready path exists.
module pipe_slice #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  // Occupancy FSM with registered handshake outputs; data regs keep stale words when emptied.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      main_q    <= RST_VAL;
      skid_q    <= RST_VAL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state     <= ONE;
            main_q    <= in_data;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state    <= TWO;
            skid_q   <= in_data;
            in_ready <= 1'b0;
          end else if (out_fire) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state    <= ONE;
            main_q   <= skid_q;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// Parametrised elastic pipeline register: STAGES cascaded skid slices plus an occupancy count.
// rst and flush both empty the pipe on the next edge; rst wins when both are high.
module pipe_reg
  import pipe_reg_pkg::*;
#(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      STAGES  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [cnt_width(STAGES)-1:0] count
);

  localparam int unsigned CW = cnt_width(STAGES);

  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];

  assign vld[0]      = in_valid;
  assign dat[0]      = in_data;
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    pipe_slice #(
      .WIDTH  (WIDTH),
      .RST_VAL(RST_VAL)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_data  (dat[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_data (dat[k+1])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES];
  assign out_data  = dat[STAGES];

  // Internal slice-to-slice moves conserve words, so only the boundary handshakes change the total.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      count <= count + CW'(in_valid & in_ready) - CW'(out_valid & out_ready);
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed scenarios on STAGES=1 and STAGES=2 instances
// plus a randomized run against a queue-based occupancy model.
module tb_pipe_reg;

  localparam int unsigned W = 16;
  localparam logic [W-1:0] RV1 = 16'hDEAD;
  localparam logic [W-1:0] RV2 = 16'hBEEF;

  logic clk;
  logic rst1, flush1, iv1, ir1, ov1, or1;
  logic [W-1:0] id1, od1;
  logic [1:0] cnt1;
  logic rst2, flush2, iv2, ir2, ov2, or2;
  logic [W-1:0] id2, od2;
  logic [2:0] cnt2;

  int checks = 0;
  int failures = 0;

  pipe_reg #(.WIDTH(W), .STAGES(1), .RST_VAL(RV1)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .count(cnt1));

  pipe_reg #(.WIDTH(W), .STAGES(2), .RST_VAL(RV2)) dut2 (
    .clk(clk), .rst(rst2), .flush(flush2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst1 = 1; rst2 = 1; iv1 = 1; iv2 = 1; id1 = 16'h1234; id2 = 16'h4321;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if ({ov1, ir1, od1, cnt1} !== {1'b0, 1'b1, RV1, 2'd0}) begin
        failures++; $display("FAIL reset1 got v=%b r=%b d=%h c=%0d", ov1, ir1, od1, cnt1); end
      checks++; if ({ov2, ir2, od2, cnt2} !== {1'b0, 1'b1, RV2, 3'd0}) begin
        failures++; $display("FAIL reset2 got v=%b r=%b d=%h c=%0d", ov2, ir2, od2, cnt2); end
    end
    iv1 = 0; iv2 = 0; rst1 = 0; rst2 = 0;
    tick();
    checks++; if ({ov1, ir1, od1, cnt1} !== {1'b0, 1'b1, RV1, 2'd0}) begin
      failures++; $display("FAIL reset1_release got v=%b r=%b d=%h c=%0d", ov1, ir1, od1, cnt1); end
    checks++; if ({ov2, ir2, od2, cnt2} !== {1'b0, 1'b1, RV2, 3'd0}) begin
      failures++; $display("FAIL reset2_release got v=%b r=%b d=%h c=%0d", ov2, ir2, od2, cnt2); end
  endtask

  task automatic test_stream();
    or1 = 1;
    for (int i = 1; i <= 8; i++) begin
      iv1 = 1; id1 = W'(i);
      tick();
      checks++; if ({ov1, od1, cnt1} !== {1'b1, W'(i), 2'd1}) begin
        failures++; $display("FAIL stream[%0d] got v=%b d=%h c=%0d exp d=%h c=1", i, ov1, od1, cnt1, i); end
    end
    iv1 = 0;
    tick();
    checks++; if ({ov1, cnt1} !== {1'b0, 2'd0}) begin
      failures++; $display("FAIL stream_drain got v=%b c=%0d exp v=0 c=0", ov1, cnt1); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    or2 = 0;
    for (int c = 0; c < 10 && ir2; c++) begin
      iv2 = 1; id2 = W'(16'hA0 + acc);
      tick();
      acc++;
    end
    iv2 = 0;
    checks++; if (acc != 4 || cnt2 !== 3'd4 || ir2 !== 1'b0) begin
      failures++; $display("FAIL bp_fill got accepted=%0d c=%0d r=%b exp 4 4 0", acc, cnt2, ir2); end
    or2 = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({ov2, od2, cnt2} !== {1'b1, W'(16'hA0 + k), 3'(4 - k)}) begin
        failures++; $display("FAIL bp_drain[%0d] got v=%b d=%h c=%0d exp d=%h c=%0d",
                             k, ov2, od2, cnt2, 16'hA0 + k, 4 - k); end
      tick();
    end
    checks++; if ({ov2, ir2, cnt2} !== {1'b0, 1'b1, 3'd0}) begin
      failures++; $display("FAIL bp_empty got v=%b r=%b c=%0d", ov2, ir2, cnt2); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] w;
    or1 = 0; iv1 = 1; id1 = 16'h0F0F;
    tick();
    or1 = 1;
    for (int c = 0; c < 10; c++) begin
      w = W'($urandom);
      id1 = w;
      tick();
      checks++; if ({ov1, ir1, od1, cnt1} !== {1'b1, 1'b1, w, 2'd1}) begin
        failures++; $display("FAIL simul[%0d] got v=%b r=%b d=%h c=%0d exp d=%h c=1",
                             c, ov1, ir1, od1, cnt1, w); end
    end
    iv1 = 0;
    tick();
  endtask

  task automatic test_flush();
    or2 = 0;
    for (int i = 0; i < 3; i++) begin
      iv2 = 1; id2 = W'(16'hB0 + i);
      tick();
    end
    checks++; if (cnt2 !== 3'd3 || ir2 !== 1'b1) begin
      failures++; $display("FAIL flush_pre got c=%0d r=%b exp 3 1", cnt2, ir2); end
    id2 = 16'h0055; flush2 = 1;
    tick();
    flush2 = 0; iv2 = 0;
    checks++; if ({cnt2, ov2, ir2, od2} !== {3'd0, 1'b0, 1'b1, RV2}) begin
      failures++; $display("FAIL flush_post got c=%0d v=%b r=%b d=%h", cnt2, ov2, ir2, od2); end
    or2 = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (ov2 !== 1'b0) begin
        failures++; $display("FAIL flush_ghost[%0d] got v=%b d=%h exp v=0", c, ov2, od2); end
    end
  endtask

  task automatic test_midop_reset();
    or1 = 0; iv1 = 1;
    id1 = 16'h0011; tick();
    id1 = 16'h0022; tick();
    iv1 = 0;
    checks++; if ({ir1, cnt1} !== {1'b0, 2'd2}) begin
      failures++; $display("FAIL midrst_full got r=%b c=%0d exp 0 2", ir1, cnt1); end
    rst1 = 1;
    tick();
    rst1 = 0;
    checks++; if ({cnt1, ir1, ov1} !== {2'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL midrst_post got c=%0d r=%b v=%b exp 0 1 0", cnt1, ir1, ov1); end
    iv1 = 1; id1 = 16'h0077; or1 = 1;
    tick();
    iv1 = 0;
    checks++; if ({ov1, od1} !== {1'b1, 16'h0077}) begin
      failures++; $display("FAIL midrst_new got v=%b d=%h exp 1 0077", ov1, od1); end
    tick();
  endtask

  // Randomized traffic; model is a FIFO per slice with capacity 2 and one move per slice per cycle.
  task automatic test_random();
    logic [W-1:0] m1 [$];
    logic [W-1:0] q0 [$];
    logic [W-1:0] q1 [$];
    logic f_in, f_mid, f_out, clr;
    flush1 = 1; flush2 = 1; iv1 = 0; iv2 = 0;
    tick();
    flush1 = 0; flush2 = 0;
    for (int c = 0; c < 500; c++) begin
      checks++; if (ir1 !== (m1.size() < 2) || ov1 !== (m1.size() > 0) ||
                    cnt1 !== 2'(m1.size()) || (m1.size() > 0 && od1 !== m1[0])) begin
        failures++; $display("FAIL rand1[%0d] got r=%b v=%b c=%0d d=%h exp occ=%0d head=%h",
                             c, ir1, ov1, cnt1, od1, m1.size(), (m1.size() > 0) ? m1[0] : '0); end
      checks++; if (ir2 !== (q0.size() < 2) || ov2 !== (q1.size() > 0) ||
                    cnt2 !== 3'(q0.size() + q1.size()) || (q1.size() > 0 && od2 !== q1[0])) begin
        failures++; $display("FAIL rand2[%0d] got r=%b v=%b c=%0d d=%h exp occ=%0d head=%h",
                             c, ir2, ov2, cnt2, od2, q0.size() + q1.size(), (q1.size() > 0) ? q1[0] : '0); end
      iv1 = 1'($urandom_range(0, 3) != 0); or1 = 1'($urandom_range(0, 2) != 0); id1 = W'($urandom);
      iv2 = 1'($urandom_range(0, 3) != 0); or2 = 1'($urandom_range(0, 2) != 0); id2 = W'($urandom);
      flush1 = ($urandom_range(0, 40) == 0); rst1 = ($urandom_range(0, 80) == 0);
      flush2 = ($urandom_range(0, 40) == 0); rst2 = ($urandom_range(0, 80) == 0);
      clr = flush1 | rst1;
      f_in = iv1 && m1.size() < 2; f_out = or1 && m1.size() > 0;
      if (clr) m1.delete();
      else begin
        if (f_out) void'(m1.pop_front());
        if (f_in) m1.push_back(id1);
      end
      clr = flush2 | rst2;
      f_in = iv2 && q0.size() < 2; f_mid = q0.size() > 0 && q1.size() < 2;
      f_out = or2 && q1.size() > 0;
      if (clr) begin q0.delete(); q1.delete(); end
      else begin
        if (f_out) void'(q1.pop_front());
        if (f_mid) q1.push_back(q0.pop_front());
        if (f_in) q0.push_back(id2);
      end
      tick();
    end
    {flush1, flush2, rst1, rst2, iv1, iv2} = '0;
  endtask

  initial begin
    {rst1, flush1, iv1, or1, rst2, flush2, iv2, or2} = '0;
    id1 = '0; id2 = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_midop_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
